// File: rtl/mc_ctrl_unit.sv
// Multi-cycle MIPS control unit: latches the fetched opcode/funct and sequences
// FETCH/DECODE/EXEC/MEM/WB with memory handshakes, timeout trap and retire counter.
module mc_ctrl_unit #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned ALUCTRL_W   = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          instr,
   input  logic                 imem_ready,
   input  logic                 dmem_ready,
   input  logic                 zero,
   output logic                 imem_req,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic                 IRWr,
   output logic                 PCWr,
   output logic [1:0]           PCSrc,
   output logic                 RegW,
   output logic                 RegDst,
   output logic                 Mem2R,
   output logic [1:0]           Alusrc,
   output logic [1:0]           ExtOp,
   output logic [ALUCTRL_W-1:0] Aluctrl,
   output logic [2:0]           state,
   output logic                 err,
   output logic [CNT_W-1:0]     retired
);

   localparam logic [ALUCTRL_W-1:0] ALUOp_ADDU = ALUCTRL_W'(1);
   localparam logic [ALUCTRL_W-1:0] ALUOp_ADD  = ALUCTRL_W'(2);
   localparam logic [ALUCTRL_W-1:0] ALUOp_SUBU = ALUCTRL_W'(3);
   localparam logic [ALUCTRL_W-1:0] ALUOp_SUB  = ALUCTRL_W'(4);
   localparam logic [ALUCTRL_W-1:0] ALUOp_AND  = ALUCTRL_W'(5);
   localparam logic [ALUCTRL_W-1:0] ALUOp_OR   = ALUCTRL_W'(6);
   localparam logic [ALUCTRL_W-1:0] ALUOp_SLT  = ALUCTRL_W'(7);
   localparam logic [ALUCTRL_W-1:0] ALUOp_SLL  = ALUCTRL_W'(8);
   localparam logic [ALUCTRL_W-1:0] ALUOp_SRL  = ALUCTRL_W'(9);
   localparam logic [ALUCTRL_W-1:0] ALUOp_SRA  = ALUCTRL_W'(10);

   localparam logic [1:0] EXT_ZERO    = 2'd0;
   localparam logic [1:0] EXT_SIGNED  = 2'd1;
   localparam logic [1:0] EXT_HIGHPOS = 2'd2;

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_t;

   state_t                 st_q, st_d;
   logic [5:0]             op_q, fn_q;
   logic [7:0]             wcnt_q, wcnt_d;
   logic [CNT_W-1:0]       ret_q;
   logic                   retire, waiting;
   logic                   is_r, is_j, is_lw, is_sw, is_beq, is_bne, is_shift, legal;
   logic [ALUCTRL_W-1:0]   alu_op;
   logic [1:0]             alu_src, ext_op;

   always_comb begin
      is_r     = (op_q == 6'b000000);
      is_j     = (op_q == 6'b000010);
      is_lw    = (op_q == 6'b100011);
      is_sw    = (op_q == 6'b101011);
      is_beq   = (op_q == 6'b000100);
      is_bne   = (op_q == 6'b000101);
      is_shift = 1'b0;
      legal    = 1'b1;
      alu_op   = '0;
      alu_src  = 2'b00;
      ext_op   = EXT_ZERO;
      if (is_r) begin
         case (fn_q)
            6'b100001: alu_op = ALUOp_ADDU;
            6'b100000: alu_op = ALUOp_ADD;
            6'b100011: alu_op = ALUOp_SUBU;
            6'b100010: alu_op = ALUOp_SUB;
            6'b101010: alu_op = ALUOp_SLT;
            6'b100100: alu_op = ALUOp_AND;
            6'b000000: begin alu_op = ALUOp_SLL; is_shift = 1'b1; end
            6'b000010: begin alu_op = ALUOp_SRL; is_shift = 1'b1; end
            6'b000011: begin alu_op = ALUOp_SRA; is_shift = 1'b1; end
            default:   legal = 1'b0;
         endcase
         if (is_shift) alu_src = 2'b11;
      end else begin
         case (op_q)
            6'b001101: alu_op = ALUOp_OR;
            6'b001111: begin alu_op = ALUOp_OR;  ext_op = EXT_HIGHPOS; end
            6'b001010: begin alu_op = ALUOp_SLT; ext_op = EXT_SIGNED;  end
            6'b100011,
            6'b101011: begin alu_op = ALUOp_ADD; ext_op = EXT_SIGNED; alu_src = 2'b01; end
            6'b000100,
            6'b000101: begin alu_op = ALUOp_SUB; ext_op = EXT_SIGNED;  end
            6'b000010: ;
            default:   legal = 1'b0;
         endcase
      end
   end

   always_comb begin
      st_d     = st_q;
      retire   = 1'b0;
      waiting  = 1'b0;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      IRWr     = 1'b0;
      PCWr     = 1'b0;
      PCSrc    = 2'b00;
      RegW     = 1'b0;
      RegDst   = 1'b0;
      Mem2R    = 1'b0;
      Alusrc   = 2'b00;
      ExtOp    = 2'b00;
      Aluctrl  = '0;
      err      = 1'b0;
      case (st_q)
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               IRWr = 1'b1;
               PCWr = 1'b1;
               st_d = DECODE;
            end else begin
               waiting = 1'b1;
               if (wcnt_q == WAIT_LAST) st_d = TRAP;
            end
         end
         DECODE: begin
            if (!legal) st_d = TRAP;
            else if (is_j) begin
               PCWr   = 1'b1;
               PCSrc  = 2'b10;
               retire = 1'b1;
               st_d   = FETCH;
            end else st_d = EXEC;
         end
         EXEC: begin
            Aluctrl = alu_op;
            Alusrc  = alu_src;
            ExtOp   = ext_op;
            if (is_beq || is_bne) begin
               if (zero == is_beq) begin
                  PCWr  = 1'b1;
                  PCSrc = 2'b01;
               end
               retire = 1'b1;
               st_d   = FETCH;
            end else if (is_lw || is_sw) st_d = MEM;
            else st_d = WB;
         end
         MEM: begin
            Aluctrl  = alu_op;
            Alusrc   = alu_src;
            ExtOp    = ext_op;
            dmem_req = 1'b1;
            dmem_we  = is_sw;
            if (dmem_ready) begin
               retire = is_sw;
               st_d   = is_sw ? FETCH : WB;
            end else begin
               waiting = 1'b1;
               if (wcnt_q == WAIT_LAST) st_d = TRAP;
            end
         end
         WB: begin
            Aluctrl = alu_op;
            Alusrc  = alu_src;
            ExtOp   = ext_op;
            RegW    = 1'b1;
            RegDst  = !is_r;
            Mem2R   = is_lw;
            retire  = 1'b1;
            st_d    = FETCH;
         end
         default: begin
            // covers TRAP and the unreachable encodings 6/7
            err  = 1'b1;
            st_d = TRAP;
         end
      endcase
      wcnt_d = (waiting && st_d == st_q) ? wcnt_q + 8'd1 : '0;
      if (rst) begin
         imem_req = 1'b0; dmem_req = 1'b0; dmem_we = 1'b0; IRWr  = 1'b0;
         PCWr     = 1'b0; PCSrc    = 2'b00; RegW  = 1'b0; RegDst = 1'b0;
         Mem2R    = 1'b0; Alusrc   = 2'b00; ExtOp = 2'b00; Aluctrl = '0;
         err      = 1'b0;
      end
   end

   assign state   = rst ? 3'd0 : st_q;
   assign retired = rst ? '0 : ret_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q   <= FETCH;
         wcnt_q <= '0;
         ret_q  <= '0;
         op_q   <= '0;
         fn_q   <= '0;
      end else begin
         st_q   <= st_d;
         wcnt_q <= wcnt_d;
         if (retire) ret_q <= ret_q + 1'b1;
         if (st_q == FETCH && imem_ready) begin
            op_q <= instr[31:26];
            fn_q <= instr[5:0];
         end
      end
   end

endmodule
